// File: rtl/bcd_counter_mdigit.sv
// bcd_counter_mdigit
// ------------------
// Multi-digit BCD up/down counter with a clock-enable prescaler. One count
// step happens every TICK_DIV enabled clock cycles. Counting can wrap or
// saturate at the ends of the range, and a synchronous parallel load
// (digit-wise clamped to 9) overrides stepping.
//
// Parameters:
//   DIGITS    number of BCD digits (q is 4*DIGITS bits, digit 0 in [3:0])
//   TICK_DIV  clk cycles per count step (>= 1; 1 = step every enabled cycle)
//   WRAP      1 = wrap around at range ends, 0 = saturate
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   en         count enable, gates prescaler and stepping
//   up         direction, 1 = up, 0 = down (sampled at the step edge)
//   load       synchronous parallel load strobe (works regardless of en)
//   load_val   BCD value to load
//   q          registered BCD count
//   tick       registered pulse, high the cycle after each step
//   carry_out  registered pulse, high the cycle after a wrap
//   tc         terminal count, combinational from q and up
module bcd_counter_mdigit #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50_000_000,
  parameter int WRAP     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tick,
  output logic                  carry_out,
  output logic                  tc
);

  localparam int QW   = 4 * DIGITS;
  // A prescaler of one cycle still needs a legal (1-bit) register.
  localparam int PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST   = PC_W'(TICK_DIV - 1);
  localparam logic [PC_W-1:0] PC_ZERO   = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);
  localparam logic [QW-1:0]   ALL_NINES = {DIGITS{4'h9}};
  localparam logic [QW-1:0]   ALL_ZEROS = {QW{1'b0}};

  // Clamp every digit above 9 down to 9 so q never holds invalid BCD.
  function automatic logic [QW-1:0] bcd_clamp(input logic [QW-1:0] v);
    logic [QW-1:0] r;
    logic [3:0]    d;
    r = ALL_ZEROS;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (d > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  // BCD increment with ripple carry; MSB of the result is carry out of the top digit.
  function automatic logic [QW:0] bcd_inc(input logic [QW-1:0] v);
    logic [QW-1:0] r;
    logic          c;
    logic [3:0]    d;
    r = ALL_ZEROS;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (!c) begin
        r[4*i +: 4] = d;
      end else if (d >= 4'd9) begin
        r[4*i +: 4] = 4'd0;
        c = 1'b1;
      end else begin
        r[4*i +: 4] = d + 4'd1;
        c = 1'b0;
      end
    end
    return {c, r};
  endfunction

  // BCD decrement with ripple borrow; MSB of the result is borrow out of the top digit.
  function automatic logic [QW:0] bcd_dec(input logic [QW-1:0] v);
    logic [QW-1:0] r;
    logic          b;
    logic [3:0]    d;
    r = ALL_ZEROS;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (!b) begin
        r[4*i +: 4] = d;
      end else if (d == 4'd0) begin
        r[4*i +: 4] = 4'd9;
        b = 1'b1;
      end else begin
        r[4*i +: 4] = d - 4'd1;
        b = 1'b0;
      end
    end
    return {b, r};
  endfunction

  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_next_s;
  logic [QW-1:0]   q_r;
  logic [QW-1:0]   q_next_s;
  logic            tick_r;
  logic            tick_next_s;
  logic            carry_r;
  logic            carry_next_s;
  logic [QW:0]     inc_s;
  logic [QW:0]     dec_s;

  // Next-state logic: load beats stepping, stepping only on the last prescaler count.
  always_comb begin
    pc_next_s    = pc_r;
    q_next_s     = q_r;
    tick_next_s  = 1'b0;
    carry_next_s = 1'b0;
    inc_s        = bcd_inc(q_r);
    dec_s        = bcd_dec(q_r);
    if (load) begin
      q_next_s  = bcd_clamp(load_val);
      pc_next_s = PC_ZERO;
    end else if (en) begin
      if (pc_r == PC_LAST) begin
        pc_next_s   = PC_ZERO;
        tick_next_s = 1'b1;
        if (up) begin
          if (!inc_s[QW]) begin
            q_next_s = inc_s[QW-1:0];
          end else if (WRAP != 0) begin
            q_next_s     = inc_s[QW-1:0];
            carry_next_s = 1'b1;
          end else begin
            // Saturate: hold at all 9s, the step still produces a tick.
            q_next_s = q_r;
          end
        end else begin
          if (!dec_s[QW]) begin
            q_next_s = dec_s[QW-1:0];
          end else if (WRAP != 0) begin
            q_next_s     = dec_s[QW-1:0];
            carry_next_s = 1'b1;
          end else begin
            // Saturate: hold at 0, the step still produces a tick.
            q_next_s = q_r;
          end
        end
      end else begin
        pc_next_s = pc_r + PC_ONE;
      end
    end else begin
      pc_next_s = pc_r;
      q_next_s  = q_r;
    end
  end

  // State and pulse registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r    <= PC_ZERO;
      q_r     <= ALL_ZEROS;
      tick_r  <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      pc_r    <= pc_next_s;
      q_r     <= q_next_s;
      tick_r  <= tick_next_s;
      carry_r <= carry_next_s;
    end
  end

  // Terminal count follows up immediately, so it is decoded combinationally.
  always_comb begin
    tc = 1'b0;
    if (up) begin
      tc = (q_r == ALL_NINES);
    end else begin
      tc = (q_r == ALL_ZEROS);
    end
  end

  assign q         = q_r;
  assign tick      = tick_r;
  assign carry_out = carry_r;

endmodule

// File: tb/tb_bcd_counter_mdigit.sv
// Scoreboard bench for bcd_counter_mdigit. Three instances share stimulus:
// A: 2 digits, TICK_DIV=4, wrap; B: 2 digits, TICK_DIV=4, saturate;
// C: 3 digits, TICK_DIV=1, wrap. The reference model keeps each count as a
// plain integer and converts to BCD only for comparison.
module tb_bcd_counter_mdigit;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [11:0] lv;
  logic [7:0]  q_a, q_b;
  logic [11:0] q_c;
  logic        tick_a, tick_b, tick_c;
  logic        co_a, co_b, co_c;
  logic        tc_a, tc_b, tc_c;

  always #5 clk = ~clk;

  bcd_counter_mdigit #(.DIGITS(2), .TICK_DIV(4), .WRAP(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .q(q_a), .tick(tick_a), .carry_out(co_a), .tc(tc_a));

  bcd_counter_mdigit #(.DIGITS(2), .TICK_DIV(4), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .q(q_b), .tick(tick_b), .carry_out(co_b), .tc(tc_b));

  bcd_counter_mdigit #(.DIGITS(3), .TICK_DIV(1), .WRAP(1)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv),
    .q(q_c), .tick(tick_c), .carry_out(co_c), .tc(tc_c));

  typedef struct packed {
    logic [11:0] qa;
    logic [11:0] qb;
    logic [11:0] qc;
    logic [2:0]  tk;
    logic [2:0]  co;
    logic [2:0]  tcv;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance
  int   nd  [3] = '{2, 2, 3};
  int   div [3] = '{4, 4, 1};
  int   wr  [3] = '{1, 0, 1};
  int   m_val [3] = '{0, 0, 0};
  int   m_pc  [3] = '{0, 0, 0};
  logic m_tick[3] = '{1'b0, 1'b0, 1'b0};
  logic m_co  [3] = '{1'b0, 1'b0, 1'b0};

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int maxv(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

  function automatic int clamp_val(input logic [11:0] v, input int digits);
    int r, p, d;
    r = 0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * p;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_val[k] = 0; m_pc[k] = 0; m_tick[k] = 1'b0; m_co[k] = 1'b0;
    end
  endtask

  // Effect of one rising edge on each modelled counter
  task automatic model_step(input logic r, input logic e, input logic u, input logic l,
                            input logic [11:0] lvv);
    for (int k = 0; k < 3; k++) begin
      m_tick[k] = 1'b0;
      m_co[k]   = 1'b0;
      if (!r) begin
        m_val[k] = 0; m_pc[k] = 0;
      end else if (l) begin
        m_val[k] = clamp_val(lvv, nd[k]); m_pc[k] = 0;
      end else if (e && m_pc[k] == div[k] - 1) begin
        m_pc[k]   = 0;
        m_tick[k] = 1'b1;
        if (u) begin
          if (m_val[k] < maxv(nd[k])) m_val[k] = m_val[k] + 1;
          else if (wr[k] != 0) begin m_val[k] = 0; m_co[k] = 1'b1; end
        end else begin
          if (m_val[k] > 0) m_val[k] = m_val[k] - 1;
          else if (wr[k] != 0) begin m_val[k] = maxv(nd[k]); m_co[k] = 1'b1; end
        end
      end else if (e) begin
        m_pc[k] = m_pc[k] + 1;
      end
    end
  endtask

  // Apply inputs for the next edge, update the model and queue the expectation
  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [11:0] lvv);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; up = u; load = l; lv = lvv;
    model_step(r, e, u, l, lvv);
    x.qa = to_bcd(m_val[0]);
    x.qb = to_bcd(m_val[1]);
    x.qc = to_bcd(m_val[2]);
    for (int k = 0; k < 3; k++) begin
      x.tk[k]  = m_tick[k];
      x.co[k]  = m_co[k];
      x.tcv[k] = u ? (m_val[k] == maxv(nd[k])) : (m_val[k] == 0);
    end
    sb.push_back(x);
  endtask

  // Reset pulled low between edges: outputs must clear before the next edge
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_q_a", {4'h0, q_a}, 12'h000);
    chk("async_q_b", {4'h0, q_b}, 12'h000);
    chk("async_q_c", q_c, 12'h000);
    chk("async_tick", {9'h000, tick_a, tick_b, tick_c}, 12'h000);
    chk("async_carry", {9'h000, co_a, co_b, co_c}, 12'h000);
    model_reset();
  endtask

  // Monitor: pop one expectation per edge and compare all outputs
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("q_a", {4'h0, q_a}, x.qa);
        chk("q_b", {4'h0, q_b}, x.qb);
        chk("q_c", q_c, x.qc);
        chk("tick", {9'h000, tick_a, tick_b, tick_c}, {9'h000, x.tk[0], x.tk[1], x.tk[2]});
        chk("carry_out", {9'h000, co_a, co_b, co_c}, {9'h000, x.co[0], x.co[1], x.co[2]});
        chk("tc", {9'h000, tc_a, tc_b, tc_c}, {9'h000, x.tcv[0], x.tcv[1], x.tcv[2]});
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; lv = 12'h000;
    // Reset held, then count down from 0 (wrap to 99 on first step)
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    repeat (16) drive(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    // Up ripple from 09, then wrap/saturate from 99
    drive(1'b1, 1'b0, 1'b1, 1'b1, 12'h009);
    repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 12'h999);
    repeat (12) drive(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    repeat (4) drive(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    // Enable dropped at pc=2 for 10 cycles
    while (m_pc[0] != 2) drive(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    repeat (10) drive(1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    // Load coincident with a step, high digit clamped
    while (m_pc[0] != 3) drive(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 12'h0A5);
    repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    // Asynchronous reset mid-count at 47
    drive(1'b1, 1'b0, 1'b1, 1'b1, 12'h047);
    repeat (2) drive(1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
    async_reset();
    repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    repeat (6) drive(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    // 998 upward on the single-cycle prescaler instance
    drive(1'b1, 1'b0, 1'b1, 1'b1, 12'h998);
    repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 12'($urandom));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 12'(sb.size()), 12'h000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter_mdigit.md
Name: bcd_counter_mdigit

Overview:
Parametrised multi-digit BCD up/down counter with a built-in clock-enable prescaler. It generalises the team's single-digit 9-to-0 down counter:
- configurable digit count and count direction
- synchronous parallel load
- wrap or saturate at the ends of the range
- carry/borrow and terminal-count outputs for cascading

It sits between the board clock and the seven-segment display driver and produces one count step per prescaler period (1 s at 50 MHz by default).

Parameters:
DIGITS, 2, number of BCD digits; q width is 4*DIGITS.
TICK_DIV, 50_000_000, clk cycles per count step; legal range is 1 or more, and 1 means a step every enabled cycle.
WRAP, 1, 1 = wrap around at the ends of the range; 0 = saturate at the ends.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
en  input  1  count enable; gates both the prescaler and stepping.
up  input  1  direction: 1 = count up, 0 = count down.
load  input  1  synchronous parallel load strobe.
load_val  input  4*DIGITS  BCD value to load; digit 0 is in bits [3:0].
q  output  4*DIGITS  current BCD count, registered.
tick  output  1  registered one-cycle pulse, high in the cycle after a count step occurs.
carry_out  output  1  registered one-cycle pulse on wrap (99..9 to 0 going up, or 0 to 99..9 going down).
tc  output  1  terminal count, combinational from q and up: 1 when (up and q = all 9s) or (!up and q = 0).

Behaviour:
- Reset (reset=0, asynchronous): q=0, prescaler=0, tick=0, carry_out=0. Reset has priority over everything and takes effect mid-operation with no clock edge needed. After reset is released, counting resumes from 0 with a full prescaler period before the first step.
- Prescaler: counter pc runs 0..TICK_DIV-1 and advances only while en=1. A step occurs on the edge where en=1 and pc=TICK_DIV-1; pc then returns to 0. While en=0, pc and q hold and no pulses are generated.
- Load: on a clock edge with load=1:
  - q takes load_val and pc is cleared to 0.
  - load takes priority over a coincident step; no tick or carry_out is generated.
  - load works regardless of en.
  - Any loaded digit greater than 9 is clamped to 9, digit by digit.
- Up step:
  - Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit (ripple through all digits within the same cycle).
  - Carry out of the top digit:
    - WRAP=1: q becomes 0 and carry_out pulses.
    - WRAP=0: q holds at all 9s and carry_out stays 0.
- Down step:
  - Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - Borrow out of the top digit:
    - WRAP=1: q becomes all 9s and carry_out pulses.
    - WRAP=0: q holds at 0 and carry_out stays 0.
- tick pulses for every step, including saturated steps where q does not change.
- Direction change: up is sampled only at the step edge. pc is not reset, so a toggle mid-period affects the next step only.
- tc reacts in the same cycle that up changes, since it is combinational.
- No invalid BCD state is ever reachable on q.
- Latency:
  - q changes on the step edge itself.
  - tick and carry_out are high for exactly the one cycle following the step edge.
  - Back-to-back pulses are possible only when TICK_DIV=1.

Test Plan:
- DIGITS=2, TICK_DIV=4, WRAP=1: hold reset=0 for 3 cycles, then release with en=1, up=0. Required: q=00 during reset; first step 4 cycles after release gives q=99 with one carry_out pulse; the next 3 steps give 98, 97, 96; one tick per step and none in between.
- Up-count ripple: load 0x09 then count up. Required: step 1 gives 10, no carry. Load 0x99 then step: q=00 with carry_out=1 for one cycle, and tc=1 during the cycle before the step.
- WRAP=0: load 0x99, up=1, run 3 steps. Required: q stays 99, tick pulses 3 times, carry_out never asserts, tc=1 throughout. Then set up=0: q steps 99 to 98.
- Enable and load: deassert en at pc=2 for 10 cycles. Required: q and pc hold and the step lands 2 enabled cycles later. Then assert load=1 with load_val=0xA5 coincident with a step: q=95 (high digit clamped to 9), no tick, and pc restarts from 0.
- Asynchronous reset mid-count: pull reset low between clock edges while q=47. Required: q=00 before the next clk edge, and tick and carry_out are 0. After release, the first step is TICK_DIV cycles later.
- TICK_DIV=1, DIGITS=3, up=1 from 998: Required: 999, then 000 with carry_out, then 001 on consecutive cycles, with tick high continuously.
